id_decode_stage: RTL

ID_DECODE_STAGE -- requirements
Module: id_decode_stage

---
 rtl/id_decode_stage.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/id_decode_stage.sv
// RV32I/RV32E instruction decode stage with a valid/ready-handshaked ID/EX slot register.
// Optional feature macro: ID_LOADUSE_STALL_EN (load-use stall against the held slot).
module id_decode_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [31:0]       i_instr,
  input  logic [XLEN-1:0]   i_pc,
  input  logic              i_flush,
  output logic [REG_AW-1:0] o_rdReg1,
  output logic [REG_AW-1:0] o_rdReg2,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [13:0]       o_ctrlEX,
  output logic [3:0]        o_ctrlMEM,
  output logic [REG_AW+2:0] o_ctrlWB,
  output logic [XLEN-1:0]   o_imm,
  output logic [XLEN-1:0]   o_pc,
  output logic [REG_AW-1:0] o_rs1,
  output logic [REG_AW-1:0] o_rs2,
  output logic              o_illegal
);

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111
  } opcode_e;

  opcode_e     opcode;
  logic [4:0]  rd_f, rs1_f, rs2_f;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = opcode_e'(i_instr[6:0]);
  assign rd_f   = i_instr[11:7];
  assign rs1_f  = i_instr[19:15];
  assign rs2_f  = i_instr[24:20];

  assign imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign imm_u = {i_instr[31:12], 12'b0};
  assign imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

  logic        legal;
  logic        use_rd, use_rs1, use_rs2;
  logic [1:0]  alu_op;
  logic        alu_src, pc_src_a;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic        jump, branch, mem_read, mem_write, reg_write;
  logic [1:0]  wb_sel;
  logic [31:0] imm32;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    legal     = 1'b1;
    use_rd    = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    alu_op    = 2'b00;
    alu_src   = 1'b0;
    pc_src_a  = 1'b0;
    func3     = 3'b000;
    func7     = 7'b0;
    jump      = 1'b0;
    branch    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    wb_sel    = 2'b00;
    imm32     = 32'b0;
    case (opcode)
      OPC_OP: begin
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        alu_op = 2'b10; func3 = i_instr[14:12]; func7 = i_instr[31:25];
        reg_write = 1'b1;
      end
      OPC_OP_IMM: begin
        use_rd = 1'b1; use_rs1 = 1'b1;
        alu_op = 2'b10; alu_src = 1'b1; func3 = i_instr[14:12];
        // Only shifts carry a meaningful func7 (arith/logical select).
        if (i_instr[13:12] == 2'b01) func7 = i_instr[31:25];
        reg_write = 1'b1; imm32 = imm_i;
      end
      OPC_LOAD: begin
        use_rd = 1'b1; use_rs1 = 1'b1;
        alu_src = 1'b1; func3 = i_instr[14:12];
        mem_read = 1'b1; reg_write = 1'b1; wb_sel = 2'b01; imm32 = imm_i;
      end
      OPC_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        alu_src = 1'b1; func3 = i_instr[14:12];
        mem_write = 1'b1; imm32 = imm_s;
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        alu_op = 2'b01; func3 = i_instr[14:12];
        branch = 1'b1; imm32 = imm_b;
      end
      OPC_LUI: begin
        use_rd = 1'b1; alu_src = 1'b1; reg_write = 1'b1; imm32 = imm_u;
      end
      OPC_AUIPC: begin
        use_rd = 1'b1; alu_src = 1'b1; pc_src_a = 1'b1; reg_write = 1'b1; imm32 = imm_u;
      end
      OPC_JAL: begin
        use_rd = 1'b1; jump = 1'b1; pc_src_a = 1'b1; alu_src = 1'b1;
        reg_write = 1'b1; wb_sel = 2'b10; imm32 = imm_j;
      end
      OPC_JALR: begin
        use_rd = 1'b1; use_rs1 = 1'b1; jump = 1'b1; alu_src = 1'b1;
        func3 = i_instr[14:12]; reg_write = 1'b1; wb_sel = 2'b10; imm32 = imm_i;
      end
      default: legal = 1'b0;
    endcase
    // RV32E has only 16 registers; a used index with bit 4 set cannot be encoded.
    if (REG_AW < 5 && ((use_rd && rd_f[4]) || (use_rs1 && rs1_f[4]) || (use_rs2 && rs2_f[4])))
      legal = 1'b0;
    if (!legal) begin
      use_rd = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0;
      alu_op = 2'b00; alu_src = 1'b0; pc_src_a = 1'b0; func3 = 3'b000; func7 = 7'b0;
      jump = 1'b0; branch = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      reg_write = 1'b0; wb_sel = 2'b00; imm32 = 32'b0;
    end
    if (rd_f == 5'd0) reg_write = 1'b0;
  end

  logic [REG_AW-1:0] dec_rd, dec_rs1, dec_rs2;
  logic [XLEN-1:0]   imm_ext;

  assign dec_rd   = use_rd  ? rd_f[REG_AW-1:0]  : '0;
  assign dec_rs1  = use_rs1 ? rs1_f[REG_AW-1:0] : '0;
  assign dec_rs2  = use_rs2 ? rs2_f[REG_AW-1:0] : '0;
  assign imm_ext  = XLEN'($signed(imm32));
  assign o_rdReg1 = dec_rs1;
  assign o_rdReg2 = dec_rs2;

  logic              valid_q;
  logic [13:0]       ctrl_ex_q;
  logic [3:0]        ctrl_mem_q;
  logic [REG_AW+2:0] ctrl_wb_q;
  logic [XLEN-1:0]   imm_q, pc_q;
  logic [REG_AW-1:0] rs1_q, rs2_q;
  logic              illegal_q;
  logic              hazard, accept;

`ifdef ID_LOADUSE_STALL_EN
  logic [REG_AW-1:0] held_rd;
  assign held_rd = ctrl_wb_q[REG_AW-1:0];
  assign hazard  = valid_q && ctrl_mem_q[1] && (held_rd != '0) &&
                   ((use_rs1 && dec_rs1 == held_rd) || (use_rs2 && dec_rs2 == held_rd));
`else
  assign hazard  = 1'b0;
`endif

  assign o_ready = (!valid_q || i_ready) && !hazard;
  assign accept  = i_valid && o_ready && !i_flush;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q    <= 1'b0;
      ctrl_ex_q  <= '0;
      ctrl_mem_q <= '0;
      ctrl_wb_q  <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      illegal_q  <= 1'b0;
    end else if (i_flush) begin
      valid_q    <= 1'b0;
    end else if (accept) begin
      valid_q    <= 1'b1;
      ctrl_ex_q  <= {alu_op, alu_src, pc_src_a, func3, func7};
      ctrl_mem_q <= {jump, branch, mem_read, mem_write};
      ctrl_wb_q  <= {reg_write, wb_sel, dec_rd};
      imm_q      <= imm_ext;
      pc_q       <= i_pc;
      rs1_q      <= dec_rs1;
      rs2_q      <= dec_rs2;
      illegal_q  <= !legal;
    end else if (i_ready) begin
      valid_q    <= 1'b0;
    end
  end

  assign o_valid   = valid_q;
  assign o_ctrlEX  = ctrl_ex_q;
  assign o_ctrlMEM = ctrl_mem_q;
  assign o_ctrlWB  = ctrl_wb_q;
  assign o_imm     = imm_q;
  assign o_pc      = pc_q;
  assign o_rs1     = rs1_q;
  assign o_rs2     = rs2_q;
  assign o_illegal = illegal_q;

endmodule
